// File: rtl/vx_writeback_arb.sv
// Commit-to-writeback arbiter: round-robin grant over execution-unit commit
// sources, 2-entry in-order writeback buffer and a retired-instruction counter.
module vx_writeback_arb #(
  parameter int NUM_REQS    = 5,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 5
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQS-1:0]             cmt_valid,
  output logic [NUM_REQS-1:0]             cmt_ready,
  input  logic [NUM_REQS*NW_BITS-1:0]     cmt_wid,
  input  logic [NUM_REQS*NUM_THREADS-1:0] cmt_tmask,
  input  logic [NUM_REQS*32-1:0]          cmt_PC,
  input  logic [NUM_REQS*NR_BITS-1:0]     cmt_rd,
  input  logic [NUM_REQS-1:0]             cmt_wb,
  input  logic [NUM_REQS-1:0]             cmt_eop,
  input  logic [NUM_REQS*NUM_THREADS*32-1:0] cmt_data,
  output logic                            wb_valid,
  input  logic                            wb_ready,
  output logic [NW_BITS-1:0]              wb_wid,
  output logic [NUM_THREADS-1:0]          wb_tmask,
  output logic [31:0]                     wb_PC,
  output logic [NR_BITS-1:0]              wb_rd,
  output logic [NUM_THREADS*32-1:0]       wb_data,
  output logic                            wb_eop,
  output logic [63:0]                     retire_cnt
);

  localparam int PW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  typedef struct packed {
    logic [NW_BITS-1:0]          wid;
    logic [NUM_THREADS-1:0]      tmask;
    logic [31:0]                 pc;
    logic [NR_BITS-1:0]          rd;
    logic [NUM_THREADS*32-1:0]   data;
    logic                        eop;
  } wb_ent_t;

  wb_ent_t req [NUM_REQS];

  generate
    for (genvar g = 0; g < NUM_REQS; g++) begin : g_req
      assign req[g] = {cmt_wid[g*NW_BITS +: NW_BITS],
                       cmt_tmask[g*NUM_THREADS +: NUM_THREADS],
                       cmt_PC[g*32 +: 32],
                       cmt_rd[g*NR_BITS +: NR_BITS],
                       cmt_data[g*NUM_THREADS*32 +: NUM_THREADS*32],
                       cmt_eop[g]};
    end
  endgenerate

  logic [PW-1:0] rr_ptr, grant, grant_hi, grant_lo;
  logic          hi_vld, lo_vld;
  logic          accept, push, pop;
  logic [1:0]    count;
  logic          head;
  wb_ent_t       ent [2];

  // Descending scan leaves the lowest valid index at/above rr_ptr (hi) and overall (lo).
  always_comb begin
    grant_hi = '0;
    grant_lo = '0;
    hi_vld   = 1'b0;
    lo_vld   = 1'b0;
    for (int j = NUM_REQS-1; j >= 0; j--) begin
      if (cmt_valid[j]) begin
        grant_lo = PW'(j);
        lo_vld   = 1'b1;
        if (PW'(j) >= rr_ptr) begin
          grant_hi = PW'(j);
          hi_vld   = 1'b1;
        end
      end
    end
  end

  assign grant  = hi_vld ? grant_hi : grant_lo;
  // No-writeback commits bypass the buffer, so only wb=1 commits need space.
  assign accept = reset_n && lo_vld && (!cmt_wb[grant] || count < 2'd2);
  assign push   = accept && cmt_wb[grant];
  assign pop    = wb_valid && wb_ready;

  always_comb begin
    cmt_ready        = '0;
    cmt_ready[grant] = accept;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr     <= '0;
      count      <= '0;
      head       <= 1'b0;
      retire_cnt <= '0;
    end else begin
      if (accept)
        rr_ptr <= (grant == PW'(NUM_REQS-1)) ? '0 : grant + 1'b1;
      count <= count + {1'b0, push} - {1'b0, pop};
      head  <= head ^ pop;
      if (accept && cmt_eop[grant])
        retire_cnt <= retire_cnt + 64'd1;
    end
  end

  // Payload needs no reset: it is only observed while count != 0.
  always_ff @(posedge clk) begin
    if (push)
      ent[head ^ count[0]] <= req[grant];
  end

  assign wb_valid = (count != 2'd0);
  assign wb_wid   = ent[head].wid;
  assign wb_tmask = ent[head].tmask;
  assign wb_PC    = ent[head].pc;
  assign wb_rd    = ent[head].rd;
  assign wb_data  = ent[head].data;
  assign wb_eop   = ent[head].eop;

endmodule

// File: tb/tb_vx_writeback_arb.sv
// Directed bench for vx_writeback_arb: round-robin order, backpressure,
// bypass of wb=0 commits, retire counting and asynchronous reset.
module tb_vx_writeback_arb;
  localparam int NR = 5, NT = 4, NWB = 2, NRB = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     cmt_valid, cmt_ready, cmt_wb, cmt_eop;
  logic [NR*NWB-1:0] cmt_wid;
  logic [NR*NT-1:0]  cmt_tmask;
  logic [NR*32-1:0]  cmt_PC;
  logic [NR*NRB-1:0] cmt_rd;
  logic [NR*NT*32-1:0] cmt_data;
  logic              wb_valid, wb_ready, wb_eop;
  logic [NWB-1:0]    wb_wid;
  logic [NT-1:0]     wb_tmask;
  logic [31:0]       wb_PC;
  logic [NRB-1:0]    wb_rd;
  logic [NT*32-1:0]  wb_data;
  logic [63:0]       retire_cnt;

  int n_cmp = 0;
  int n_err = 0;

  vx_writeback_arb #(.NUM_REQS(NR), .NUM_THREADS(NT), .NW_BITS(NWB), .NR_BITS(NRB)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_wid(cmt_wid),
    .cmt_tmask(cmt_tmask), .cmt_PC(cmt_PC), .cmt_rd(cmt_rd), .cmt_wb(cmt_wb),
    .cmt_eop(cmt_eop), .cmt_data(cmt_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wid(wb_wid), .wb_tmask(wb_tmask),
    .wb_PC(wb_PC), .wb_rd(wb_rd), .wb_data(wb_data), .wb_eop(wb_eop),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic wb, input logic eop,
                         input logic [NWB-1:0] wid, input logic [NT-1:0] tm,
                         input logic [31:0] pc, input logic [NRB-1:0] rd,
                         input logic [NT*32-1:0] d);
    cmt_valid[i] = v;
    cmt_wb[i]    = wb;
    cmt_eop[i]   = eop;
    cmt_wid[i*NWB +: NWB]        = wid;
    cmt_tmask[i*NT +: NT]        = tm;
    cmt_PC[i*32 +: 32]           = pc;
    cmt_rd[i*NRB +: NRB]         = rd;
    cmt_data[i*NT*32 +: NT*32]   = d;
  endtask

  initial begin
    int gseq [6];
    logic [NR-1:0] exp_rdy;
    gseq = '{0, 2, 4, 0, 2, 4};

    reset_n = 1'b0; wb_ready = 1'b1;
    cmt_valid = '0; cmt_wb = '0; cmt_eop = '0; cmt_wid = '0; cmt_tmask = '0;
    cmt_PC = '0; cmt_rd = '0; cmt_data = '0;
    #2;
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_retire", retire_cnt, 64'd0);
    cmt_valid[0] = 1'b1;
    #1;
    chk("rst_cmt_ready", cmt_ready, 5'b00000);
    cmt_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Sources 0,2,4 always valid: strict rotation, wb_valid from the first cycle on.
    for (int s = 0; s < NR; s += 2)
      set_src(s, 1'b1, 1'b1, 1'b1, 2'd0, 4'hF, 32'h100 + 32'(s), 5'(10 + s), 128'(s));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_rdy = '0;
      exp_rdy[gseq[k]] = 1'b1;
      chk($sformatf("rr_ready_%0d", k), cmt_ready, exp_rdy);
      tick();
      chk($sformatf("rr_wb_valid_%0d", k), wb_valid, 1'b1);
      chk($sformatf("rr_wb_rd_%0d", k), wb_rd, 5'(10 + gseq[k]));
    end
    cmt_valid = '0;
    tick();
    chk("rr_drained", wb_valid, 1'b0);
    chk("rr_retire", retire_cnt, 64'd6);

    // Single ALU commit: fields appear one cycle later.
    set_src(0, 1'b1, 1'b1, 1'b1, 2'd1, 4'b1011, 32'h8000_0010, 5'd5,
            128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D);
    @(negedge clk);
    chk("alu_ready", cmt_ready, 5'b00001);
    tick();
    cmt_valid = '0;
    chk("alu_wb_valid", wb_valid, 1'b1);
    chk("alu_wid", wb_wid, 2'd1);
    chk("alu_tmask", wb_tmask, 4'b1011);
    chk("alu_pc", wb_PC, 32'h8000_0010);
    chk("alu_rd", wb_rd, 5'd5);
    chk("alu_data", wb_data, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D);
    chk("alu_eop", wb_eop, 1'b1);
    chk("alu_retire", retire_cnt, 64'd7);
    tick();
    chk("alu_popped", wb_valid, 1'b0);

    // eop=0 then eop=1 on a non-writeback source.
    set_src(1, 1'b1, 1'b0, 1'b0, 2'd2, 4'h1, 32'h200, 5'd1, 128'h0);
    @(negedge clk);
    chk("eop0_ready", cmt_ready, 5'b00010);
    tick();
    cmt_valid = '0;
    chk("eop0_retire", retire_cnt, 64'd7);
    chk("eop0_no_wb", wb_valid, 1'b0);
    set_src(1, 1'b1, 1'b0, 1'b1, 2'd2, 4'h1, 32'h204, 5'd1, 128'h0);
    @(negedge clk);
    chk("eop1_ready_wrap", cmt_ready, 5'b00010);
    tick();
    cmt_valid = '0;
    chk("eop1_retire", retire_cnt, 64'd8);

    // Backpressure: two accepts fill the buffer, the third is held off.
    wb_ready = 1'b0;
    set_src(1, 1'b1, 1'b1, 1'b1, 2'd0, 4'h3, 32'h300, 5'd3, 128'h3);
    @(negedge clk);
    chk("bp_ready_a", cmt_ready, 5'b00010);
    tick();
    chk("bp_rd_a", wb_rd, 5'd3);
    set_src(1, 1'b1, 1'b1, 1'b1, 2'd0, 4'h3, 32'h304, 5'd7, 128'h7);
    @(negedge clk);
    chk("bp_ready_b", cmt_ready, 5'b00010);
    tick();
    chk("bp_rd_hold_b", wb_rd, 5'd3);
    set_src(1, 1'b1, 1'b1, 1'b1, 2'd0, 4'h3, 32'h308, 5'd9, 128'h9);
    @(negedge clk);
    chk("bp_ready_full", cmt_ready, 5'b00000);
    tick();
    cmt_valid = '0;
    chk("bp_rd_hold_c", wb_rd, 5'd3);
    chk("bp_retire", retire_cnt, 64'd10);

    // wb=0 commit bypasses a full buffer.
    set_src(2, 1'b1, 1'b0, 1'b1, 2'd0, 4'h1, 32'h400, 5'd2, 128'h0);
    @(negedge clk);
    chk("byp_ready", cmt_ready, 5'b00100);
    tick();
    cmt_valid = '0;
    chk("byp_retire", retire_cnt, 64'd11);
    chk("byp_wb_valid", wb_valid, 1'b1);
    chk("byp_rd", wb_rd, 5'd3);

    wb_ready = 1'b1;
    tick();
    chk("drain_valid_b", wb_valid, 1'b1);
    chk("drain_rd_b", wb_rd, 5'd7);
    chk("drain_pc_b", wb_PC, 32'h304);
    tick();
    chk("drain_empty", wb_valid, 1'b0);

    // Refill to two entries, then reset asynchronously between edges.
    wb_ready = 1'b0;
    set_src(3, 1'b1, 1'b1, 1'b0, 2'd0, 4'h1, 32'h500, 5'd20, 128'h0);
    tick();
    set_src(3, 1'b1, 1'b1, 1'b0, 2'd0, 4'h1, 32'h504, 5'd21, 128'h0);
    tick();
    chk("refill_rd", wb_rd, 5'd20);
    cmt_valid = '0;
    set_src(2, 1'b1, 1'b1, 1'b0, 2'd0, 4'h1, 32'h600, 5'd22, 128'h0);
    set_src(4, 1'b1, 1'b1, 1'b0, 2'd0, 4'h1, 32'h700, 5'd24, 128'h0);
    #1;
    chk("full_ready", cmt_ready, 5'b00000);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_wb_valid", wb_valid, 1'b0);
    chk("arst_ready", cmt_ready, 5'b00000);
    chk("arst_retire", retire_cnt, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", cmt_ready, 5'b00100);
    chk("post_rst_empty", wb_valid, 1'b0);
    tick();
    chk("post_rst_valid", wb_valid, 1'b1);
    chk("post_rst_rd", wb_rd, 5'd22);
    cmt_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
